// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffer.
// Macro UART_TX_PARITY_EN selects the 8E1 frame (parity bit after data).
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int unsigned DEF_CLK_PER_BIT = 868;
  localparam int unsigned DEF_DEPTH       = 16;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Core-side transmit port plus line and status outputs of the UART buffer.
interface uart_tx_buffer_if;
  logic       tx_ready;
  logic [7:0] sdata;
  logic       txd;
  logic       busy;
  logic       full;
  logic       overflow;

  modport master (output tx_ready, sdata, input txd, busy, full, overflow);
  modport slave  (input tx_ready, sdata, output txd, busy, full, overflow);
endinterface

// File: rtl/uart_tx_buffer_tx_fifo.sv
// Synchronous single-clock byte FIFO with first-word-fall-through read data.
module tx_fifo #(
  parameter int unsigned DEPTH = uart_pkg::DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered UART transmitter: FIFO of core bytes serialised as 8N1 on txd.
// Macro UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int unsigned DEPTH       = DEF_DEPTH
) (
  input logic             clk,
  input logic             rst,
  uart_tx_buffer_if.slave bus
);
  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                overflow_q;
  logic                tick, pop;
  logic [7:0]          fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.tx_ready),
    .pop_i   (pop),
    .din_i   (bus.sdata),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tick = (cnt_q == CNT_MAX);

  // FSM state, baud counter, shifter and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Sticky drop flag: a strobe that meets a full FIFO is lost.
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else if (bus.tx_ready && fifo_full) overflow_q <= 1'b1;
  end

  // Next-state, pop and line level; txd is derived from the next state so
  // the registered line changes on the same edge the state does.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    cnt_d   = (state_q == S_IDLE || tick) ? '0 : cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_dout;
`endif
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            idx_d   = '0;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_dout;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = (state_q != S_IDLE) || (fifo_count != '0);
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer at CLK_PER_BIT=4, DEPTH=4.
module tb_uart_tx_buffer;
  localparam int unsigned CPB = 4;
  localparam int unsigned FL  = uart_pkg::FRAME_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_buffer_if bus ();

  uart_tx_buffer #(.CLK_PER_BIT(CPB), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called just after the edge that pushed the first byte; checks every
  // line cycle of n consecutive frames and the idle state afterwards.
  task automatic expect_frames(input logic [7:0] bytes [8], input int unsigned n,
                               input string name);
    logic [7:0] dec;
    logic       exp;
    @(negedge clk);
    checks++;
    if (bus.txd !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s pre-start txd=%b busy=%b expected txd=1 busy=1", name, bus.txd, bus.busy);
    end
    for (int unsigned f = 0; f < n; f++) begin
      dec = '0;
      for (int unsigned k = 0; k < FL; k++) begin
        for (int unsigned c = 0; c < CPB; c++) begin
          @(negedge clk);
          exp = frame_bit(bytes[f], k);
          checks++;
          if (bus.txd !== exp) begin
            failures++;
            $display("FAIL %s frame %0d bit %0d cycle %0d txd=%b expected %b",
                     name, f, k, c, bus.txd, exp);
          end
          if (c == CPB/2 && k >= 1 && k <= 8) dec[k-1] = bus.txd;
        end
      end
      checks++;
      if (dec !== bytes[f]) begin
        failures++;
        $display("FAIL %s decoded byte %0d = %h expected %h", name, f, dec, bytes[f]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.txd !== 1'b1) begin
      failures++;
      $display("FAIL %s post-frame busy=%b txd=%b expected busy=0 txd=1", name, bus.busy, bus.txd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    bus.sdata = 8'h00;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
        failures++;
        $display("FAIL reset cycle %0d txd=%b busy=%b full=%b ovf=%b expected 1 0 0 0",
                 i, bus.txd, bus.busy, bus.full, bus.overflow);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] q [8];
    q[0] = 8'h55;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.sdata = 8'h55;
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
    expect_frames(q, 1, "single_55");
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [8];
    q[0] = 8'h41; q[1] = 8'h42; q[2] = 8'h43;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.sdata = 8'h41;
    @(posedge clk);
    #1;
    fork
      begin
        bus.sdata = 8'h42;
        @(posedge clk);
        #1 bus.sdata = 8'h43;
        @(posedge clk);
        #1 bus.tx_ready = 1'b0;
      end
      expect_frames(q, 3, "back_to_back");
    join
  endtask

  task automatic test_overflow();
    logic [7:0] q [8];
    for (int unsigned i = 0; i < 5; i++) q[i] = 8'(i);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.sdata = 8'h00;
    @(posedge clk);
    #1;
    fork
      begin
        for (int unsigned i = 1; i < 6; i++) begin
          bus.sdata = 8'(i);
          @(posedge clk);
          #1;
          if (i == 4) begin
            checks++;
            if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
              failures++;
              $display("FAIL ovf_fill full=%b ovf=%b expected full=1 ovf=0", bus.full, bus.overflow);
            end
          end
          if (i == 5) begin
            checks++;
            if (bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
              failures++;
              $display("FAIL ovf_drop full=%b ovf=%b expected full=1 ovf=1", bus.full, bus.overflow);
            end
          end
        end
        bus.tx_ready = 1'b0;
      end
      expect_frames(q, 5, "overflow_frames");
    join
    checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky ovf=%b full=%b expected ovf=1 full=0", bus.overflow, bus.full);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.sdata = 8'hFF;
    @(posedge clk);
    #1 bus.sdata = 8'hAA;
    @(posedge clk);
    #1 bus.sdata = 8'hBB;
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
    // Now just past E2; data bit 3 occupies the cycles after E17..E20.
    repeat (16) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre busy=%b ovf=%b expected busy=1 ovf=1", bus.busy, bus.overflow);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid txd=%b busy=%b full=%b ovf=%b expected 1 0 0 0",
               bus.txd, bus.busy, bus.full, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_quiet cycle %0d txd=%b busy=%b expected txd=1 busy=0",
                 i, bus.txd, bus.busy);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] q [8];
    q[0] = 8'h07;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.sdata = 8'h07;
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
    expect_frames(q, 1, "parity_07");
    q[0] = 8'h03;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.sdata = 8'h03;
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
    expect_frames(q, 1, "parity_03");
  endtask
`endif

  initial begin
    bus.tx_ready = 1'b0;
    bus.sdata = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
